// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN output stage: display modes, argmax FSM
// encoding and a width-agnostic score comparator.
package cnn_pkg;

    localparam logic [1:0] MODE_SCAN   = 2'd0;
    localparam logic [1:0] MODE_ARGMAX = 2'd1;
    localparam logic [1:0] MODE_SEL    = 2'd2;
    localparam logic [1:0] MODE_BLANK  = 2'd3;

    localparam int SCORE_MAX_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } argmax_state_e;

    // Flipping the sign bit maps two's-complement order onto unsigned order,
    // so a single unsigned compare serves both modes.
    function automatic logic score_gt(
        input logic [SCORE_MAX_W-1:0] a,
        input logic [SCORE_MAX_W-1:0] b,
        input int unsigned            w,
        input logic                   signed_cmp
    );
        logic [SCORE_MAX_W-1:0] bias;
        bias = signed_cmp ? (SCORE_MAX_W'(1) << (w - 1)) : '0;
        return (a ^ bias) > (b ^ bias);
    endfunction

endpackage

// File: rtl/cnn_result_display_if.sv
// Bus between the dense layer / board controls and the result display stage.
interface cnn_result_display_if #(
    parameter int N_CLASS = 7,
    parameter int DATA_W  = 8
);
    localparam int IDX_W = $clog2(N_CLASS);

    logic                      valid_i;
    logic [N_CLASS*DATA_W-1:0] data_i;
    logic [1:0]                mode_i;
    logic [IDX_W-1:0]          sel_i;
    logic [DATA_W-1:0]         led_o;
    logic [IDX_W-1:0]          class_o;
    logic                      class_valid_o;
    logic                      busy_o;

    modport master (
        output valid_i, data_i, mode_i, sel_i,
        input  led_o, class_o, class_valid_o, busy_o
    );

    modport slave (
        input  valid_i, data_i, mode_i, sel_i,
        output led_o, class_o, class_valid_o, busy_o
    );

endinterface

// File: rtl/argmax_seq.sv
// Captures a score vector and finds its argmax with one compare per cycle;
// a new capture always aborts and restarts the search.
module argmax_seq
    import cnn_pkg::*;
#(
    parameter  int N_CLASS    = 7,
    parameter  int DATA_W     = 8,
    parameter  int SIGNED_CMP = 1,
    localparam int IDX_W      = $clog2(N_CLASS)
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      valid_i,
    input  logic [N_CLASS*DATA_W-1:0] data_i,
    output logic [N_CLASS*DATA_W-1:0] vec_o,
    output logic [IDX_W-1:0]          class_o,
    output logic                      class_valid_o,
    output logic                      busy_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASS - 1);

    argmax_state_e             state_q;
    logic [N_CLASS*DATA_W-1:0] vec_q;
    logic [DATA_W-1:0]         best_val_q;
    logic [IDX_W-1:0]          best_idx_q;
    logic [IDX_W-1:0]          cmp_idx_q;
    logic [IDX_W-1:0]          class_q;
    logic                      class_valid_q;
    logic                      busy_q;

    logic [DATA_W-1:0]         cand;
    logic                      take;

    always_comb begin
        cand = '0;
        for (int k = 0; k < N_CLASS; k++) begin
            if (cmp_idx_q == IDX_W'(k)) begin
                cand = vec_q[k*DATA_W +: DATA_W];
            end
        end
    end

    // Strictly greater only, so ties keep the lowest index.
    assign take = score_gt(SCORE_MAX_W'(cand), SCORE_MAX_W'(best_val_q),
                           DATA_W, SIGNED_CMP != 0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            vec_q         <= '0;
            best_val_q    <= '0;
            best_idx_q    <= '0;
            cmp_idx_q     <= '0;
            class_q       <= '0;
            class_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else if (valid_i) begin
            state_q       <= ST_SEARCH;
            vec_q         <= data_i;
            best_val_q    <= data_i[DATA_W-1:0];
            best_idx_q    <= '0;
            cmp_idx_q     <= IDX_W'(1);
            class_valid_q <= 1'b0;
            busy_q        <= 1'b1;
        end else begin
            case (state_q)
                ST_SEARCH: begin
                    if (take) begin
                        best_val_q <= cand;
                        best_idx_q <= cmp_idx_q;
                    end
                    cmp_idx_q <= cmp_idx_q + IDX_W'(1);
                    // The final compare's winner is published on the same edge.
                    if (cmp_idx_q == LAST_IDX) begin
                        class_q       <= take ? cmp_idx_q : best_idx_q;
                        class_valid_q <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= ST_DONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign vec_o         = vec_q;
    assign class_o       = class_q;
    assign class_valid_o = class_valid_q;
    assign busy_o        = busy_q;

endmodule

// File: rtl/cnn_result_display.sv
// End-of-pipeline display stage: argmax search plus a registered LED mux
// offering timed scan, one-hot class, manual select and blank.
module cnn_result_display
    import cnn_pkg::*;
#(
    parameter int N_CLASS    = 7,
    parameter int DATA_W     = 8,
    parameter int DWELL      = 10000,
    parameter int SIGNED_CMP = 1
) (
    input logic                  clk,
    input logic                  resetn,
    cnn_result_display_if.slave  bus
);

    localparam int IDX_W   = $clog2(N_CLASS);
    localparam int DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_CLASS - 1);

    if (N_CLASS < 2 || N_CLASS > DATA_W) begin : g_bad_n_class
        $error("cnn_result_display: N_CLASS must be in 2..DATA_W");
    end
    if (DWELL < 1) begin : g_bad_dwell
        $error("cnn_result_display: DWELL must be >= 1");
    end
    if (DATA_W > SCORE_MAX_W) begin : g_bad_data_w
        $error("cnn_result_display: DATA_W exceeds comparator width");
    end

    logic [N_CLASS*DATA_W-1:0] vec;
    logic [IDX_W-1:0]          class_w;
    logic                      class_valid_w;
    logic                      busy_w;

    logic [1:0]                mode_q;
    logic [DWELL_W-1:0]        dwell_q, dwell_d;
    logic [IDX_W-1:0]          scan_idx_q, scan_idx_d;
    logic [DATA_W-1:0]         led_q, led_d;

    argmax_seq #(
        .N_CLASS    (N_CLASS),
        .DATA_W     (DATA_W),
        .SIGNED_CMP (SIGNED_CMP)
    ) u_argmax (
        .clk           (clk),
        .resetn        (resetn),
        .valid_i       (bus.valid_i),
        .data_i        (bus.data_i),
        .vec_o         (vec),
        .class_o       (class_w),
        .class_valid_o (class_valid_w),
        .busy_o        (busy_w)
    );

    function automatic logic [DATA_W-1:0] pick(
        input logic [N_CLASS*DATA_W-1:0] v,
        input logic [IDX_W-1:0]          idx
    );
        logic [DATA_W-1:0] r;
        r = '0;
        for (int k = 0; k < N_CLASS; k++) begin
            if (idx == IDX_W'(k)) begin
                r = v[k*DATA_W +: DATA_W];
            end
        end
        return r;
    endfunction

    // A new vector or any mode change restarts the scan from element 0.
    always_comb begin
        dwell_d    = dwell_q;
        scan_idx_d = scan_idx_q;
        if (bus.valid_i || (bus.mode_i != mode_q)) begin
            dwell_d    = '0;
            scan_idx_d = '0;
        end else if (dwell_q == DWELL_LAST) begin
            dwell_d    = '0;
            scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IDX_W'(1);
        end else begin
            dwell_d    = dwell_q + DWELL_W'(1);
        end
    end

    always_comb begin
        led_d = '0;
        case (bus.mode_i)
            MODE_SCAN:   led_d = pick(vec, scan_idx_q);
            MODE_ARGMAX: led_d = class_valid_w ? (DATA_W'(1) << class_w) : '0;
            MODE_SEL:    led_d = pick(vec, bus.sel_i);
            default:     led_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mode_q     <= MODE_SCAN;
            dwell_q    <= '0;
            scan_idx_q <= '0;
            led_q      <= '0;
        end else begin
            mode_q     <= bus.mode_i;
            dwell_q    <= dwell_d;
            scan_idx_q <= scan_idx_d;
            led_q      <= led_d;
        end
    end

    assign bus.led_o         = led_q;
    assign bus.class_o       = class_w;
    assign bus.class_valid_o = class_valid_w;
    assign bus.busy_o        = busy_w;

endmodule

// File: tb/tb_cnn_result_display.sv
// Directed bench for cnn_result_display: signed (DWELL=4) and unsigned
// (DWELL=1) instances share one stimulus stream.
module tb_cnn_result_display;
    import cnn_pkg::*;

    localparam int N_CLASS = 7;
    localparam int DATA_W  = 8;
    localparam int IDX_W   = 3;

    typedef struct {
        logic [N_CLASS*DATA_W-1:0] data;
        logic [IDX_W-1:0]          expSigned;
        logic [IDX_W-1:0]          expUnsigned;
    } argVec_t;

    logic                      clk = 1'b0;
    logic                      resetn;
    logic                      validIn;
    logic [N_CLASS*DATA_W-1:0] dataIn;
    logic [1:0]                modeIn;
    logic [IDX_W-1:0]          selIn;

    int nApplied;
    int nFail;

    argVec_t vecTable [6];

    cnn_result_display_if #(.N_CLASS(N_CLASS), .DATA_W(DATA_W)) busA ();
    cnn_result_display_if #(.N_CLASS(N_CLASS), .DATA_W(DATA_W)) busB ();

    assign busA.valid_i = validIn;
    assign busA.data_i  = dataIn;
    assign busA.mode_i  = modeIn;
    assign busA.sel_i   = selIn;
    assign busB.valid_i = validIn;
    assign busB.data_i  = dataIn;
    assign busB.mode_i  = modeIn;
    assign busB.sel_i   = selIn;

    cnn_result_display #(
        .N_CLASS(N_CLASS), .DATA_W(DATA_W), .DWELL(4), .SIGNED_CMP(1)
    ) dutA (
        .clk(clk), .resetn(resetn), .bus(busA)
    );

    cnn_result_display #(
        .N_CLASS(N_CLASS), .DATA_W(DATA_W), .DWELL(1), .SIGNED_CMP(0)
    ) dutB (
        .clk(clk), .resetn(resetn), .bus(busB)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [N_CLASS*DATA_W-1:0] d, input logic [1:0] m);
        validIn = 1'b1;
        dataIn  = d;
        modeIn  = m;
        @(negedge clk);
        validIn = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nApplied++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N_CLASS*DATA_W-1:0] vClass4, v1, v2, vScan;
        int n;

        nApplied = 0;
        nFail    = 0;
        validIn  = 1'b0;
        dataIn   = '0;
        modeIn   = MODE_SCAN;
        selIn    = '0;
        resetn   = 1'b0;

        // Elements written high index first: {e6,e5,e4,e3,e2,e1,e0}
        vecTable[0] = '{{8'd5, 8'd0, 8'd1, 8'd9, 8'd2, 8'd9, 8'd3}, 3'd1, 3'd1};
        vecTable[1] = '{{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h80}, 3'd1, 3'd0};
        vecTable[2] = '{{8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4, 8'd4}, 3'd0, 3'd0};
        vecTable[3] = '{{8'd100, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 3'd6, 3'd6};
        vecTable[4] = '{{8'hFC, 8'hF7, 8'hF9, 8'hFE, 8'hFF, 8'hFD, 8'hFB}, 3'd2, 3'd2};
        vecTable[5] = '{{8'd5, 8'd4, 8'd50, 8'd3, 8'd2, 8'd1, 8'd0}, 3'd4, 3'd4};

        vClass4 = vecTable[5].data;
        v1      = vecTable[0].data;
        v2      = {8'd6, 8'd90, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        vScan   = {8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10, 8'd0};

        tick(3);
        checkOutput("resetLed", busA.led_o, 0);
        checkOutput("resetClass", busA.class_o, 0);
        checkOutput("resetClassValid", busA.class_valid_o, 0);
        checkOutput("resetBusy", busA.busy_o, 0);
        resetn = 1'b1;

        tick(2);
        checkOutput("preCaptureScanLed", busA.led_o, 0);
        modeIn = MODE_SEL;
        selIn  = 3'd3;
        tick(2);
        checkOutput("preCaptureSelLed", busA.led_o, 0);
        modeIn = MODE_SCAN;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecTable[i].data, MODE_SCAN);
            checkOutput($sformatf("v%0d busyAfterCapture", i), busA.busy_o, 1);
            checkOutput($sformatf("v%0d validAfterCapture", i), busA.class_valid_o, 0);
            tick(5);
            checkOutput($sformatf("v%0d busyEdge5", i), busA.busy_o, 1);
            checkOutput($sformatf("v%0d validEdge5", i), busA.class_valid_o, 0);
            tick(1);
            checkOutput($sformatf("v%0d validEdge6", i), busA.class_valid_o, 1);
            checkOutput($sformatf("v%0d busyEdge6", i), busA.busy_o, 0);
            checkOutput($sformatf("v%0d classSigned", i), busA.class_o, vecTable[i].expSigned);
            checkOutput($sformatf("v%0d classUnsigned", i), busB.class_o, vecTable[i].expUnsigned);
            tick(2);
            checkOutput($sformatf("v%0d classHeld", i), busA.class_o, vecTable[i].expSigned);
            checkOutput($sformatf("v%0d validHeld", i), busA.class_valid_o, 1);
        end

        // Argmax display, then an aborted search restarted 3 edges in
        applyStimulus(vClass4, MODE_ARGMAX);
        tick(6);
        checkOutput("argClass4", busA.class_o, 4);
        tick(1);
        checkOutput("argLedOneHot4", busA.led_o, 32'h10);
        applyStimulus(v1, MODE_ARGMAX);
        tick(2);
        checkOutput("argLedBlankInSearch", busA.led_o, 0);
        checkOutput("argBusyInSearch", busA.busy_o, 1);
        applyStimulus(v2, MODE_ARGMAX);
        tick(3);
        checkOutput("abortNoPartialResult", busA.class_valid_o, 0);
        tick(2);
        checkOutput("abortValidEdge5", busA.class_valid_o, 0);
        checkOutput("abortBusyEdge5", busA.busy_o, 1);
        tick(1);
        checkOutput("abortValidEdge6", busA.class_valid_o, 1);
        checkOutput("abortClass", busA.class_o, 5);
        tick(1);
        checkOutput("argLedOneHot5", busA.led_o, 32'h20);

        // Select and blank modes on v2
        modeIn = MODE_SEL;
        selIn  = 3'd6;
        tick(1);
        checkOutput("selIdx6", busA.led_o, 6);
        selIn = 3'd5;
        tick(1);
        checkOutput("selIdx5", busA.led_o, 90);
        selIn = 3'd7;
        tick(1);
        checkOutput("selOutOfRange", busA.led_o, 0);
        modeIn = MODE_BLANK;
        selIn  = 3'd5;
        tick(1);
        checkOutput("blankLed", busA.led_o, 0);

        // Scan: A holds each element 4 cycles, B advances every cycle
        applyStimulus(vScan, MODE_SCAN);
        n = 0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            n = n + 1;
            checkOutput($sformatf("scanA k%0d first", k), busA.led_o, (k % 7) * 10);
            checkOutput($sformatf("scanB n%0d", n), busB.led_o, ((n - 1) % 7) * 10);
            tick(3);
            n = n + 3;
            checkOutput($sformatf("scanA k%0d last", k), busA.led_o, (k % 7) * 10);
            checkOutput($sformatf("scanB n%0d", n), busB.led_o, ((n - 1) % 7) * 10);
        end

        modeIn = MODE_SEL;
        selIn  = 3'd3;
        tick(1);
        checkOutput("toggleSelLed", busA.led_o, 30);
        modeIn = MODE_SCAN;
        tick(2);
        checkOutput("restartElem0First", busA.led_o, 0);
        tick(3);
        checkOutput("restartElem0Last", busA.led_o, 0);
        tick(1);
        checkOutput("restartElem1", busA.led_o, 10);

        // Reset mid-search and mid-scan, with a capture on the same edge
        applyStimulus(v1, MODE_SCAN);
        tick(2);
        resetn  = 1'b0;
        validIn = 1'b1;
        dataIn  = v2;
        tick(1);
        checkOutput("midResetLed", busA.led_o, 0);
        checkOutput("midResetClass", busA.class_o, 0);
        checkOutput("midResetClassB", busB.class_o, 0);
        checkOutput("midResetValid", busA.class_valid_o, 0);
        checkOutput("midResetBusy", busA.busy_o, 0);
        resetn  = 1'b1;
        validIn = 1'b0;
        tick(1);
        checkOutput("postResetIdle", busA.busy_o, 0);
        tick(5);
        checkOutput("postResetScanLed", busA.led_o, 0);
        checkOutput("postResetValid", busA.class_valid_o, 0);
        modeIn = MODE_SEL;
        selIn  = 3'd1;
        tick(2);
        checkOutput("postResetSelLed", busA.led_o, 0);
        modeIn = MODE_ARGMAX;
        tick(2);
        checkOutput("postResetArgLed", busA.led_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nFail);
        $finish;
    end

endmodule
